max7219_chain_checker: RTL and testbench

//  Bench-side emulator/checker for a daisy chain of G_NB_DEVICES MAX7219 drivers sharing CLK/LOAD.

---
 rtl/max7219_chain_checker_pkg.sv | 26 ++
 rtl/max7219_chain_regfile.sv | 23 ++
 rtl/max7219_chain_checker.sv | 129 ++++++++++++
 tb/tb_max7219_chain_checker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/max7219_chain_checker_pkg.sv
// max7219_checker_pkg: MAX7219 register addresses, decoded word type and address validity helper
package max7219_checker_pkg;
  localparam logic [3:0] NO_OP        = 4'h0;
  localparam logic [3:0] DIGIT_0      = 4'h1;
  localparam logic [3:0] DIGIT_1      = 4'h2;
  localparam logic [3:0] DIGIT_2      = 4'h3;
  localparam logic [3:0] DIGIT_3      = 4'h4;
  localparam logic [3:0] DIGIT_4      = 4'h5;
  localparam logic [3:0] DIGIT_5      = 4'h6;
  localparam logic [3:0] DIGIT_6      = 4'h7;
  localparam logic [3:0] DIGIT_7      = 4'h8;
  localparam logic [3:0] DECODE_MODE  = 4'h9;
  localparam logic [3:0] INTENSITY    = 4'hA;
  localparam logic [3:0] SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] SHUTDOWN     = 4'hC;
  localparam logic [3:0] DISPLAY_TEST = 4'hF;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } max7219_register_struct_t;

  function automatic logic addr_is_valid(input logic [3:0] addr);
    return (addr >= DIGIT_0 && addr <= SHUTDOWN) || addr == DISPLAY_TEST;
  endfunction
endpackage

// File: rtl/max7219_chain_regfile.sv
// max7219_chain_regfile: register file of one MAX7219 device with asynchronous read port
module max7219_chain_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem [16];

  // Clear on reset, otherwise write the addressed register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[addr] <= data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/max7219_chain_checker.sv
// max7219_chain_checker: MAX7219 daisy-chain bus emulator/checker; define MAX7219_CHAIN_CHECKER_REPORT_EN for frame reports
module max7219_chain_checker
  import max7219_checker_pkg::*;
#(
  parameter int G_NB_DEVICES = 4,
  parameter int G_MATRIX_ID  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_max7219_clk,
  input  logic                    i_max7219_din,
  input  logic                    i_max7219_load,
  output logic                    o_max7219_dout,
  input  logic                    i_rd_req,
  input  logic [3:0]              i_rd_dev,
  input  logic [3:0]              i_rd_addr,
  output logic                    o_rd_valid,
  output logic [7:0]              o_rd_data,
  output logic                    o_frame_received,
  output logic                    o_frame_err,
  output logic [G_NB_DEVICES-1:0] o_dev_written,
  output logic [15:0]             o_frame_cnt,
  output logic [15:0]             o_err_cnt
);
  localparam int W  = 16 * G_NB_DEVICES;
  localparam int CW = $clog2(W + 2);

  logic clk_q, load_q, din_q;
  logic clk_rise, load_rise, cnt_ok, any_bad, good;
  logic [W-1:0] sr;
  logic [CW-1:0] cnt;
  logic [G_NB_DEVICES-1:0] we;
  logic [7:0] rd_all [G_NB_DEVICES];
  logic [7:0] rd_sel;
  max7219_register_struct_t word [G_NB_DEVICES];

  assign clk_rise  = i_max7219_clk & ~clk_q;
  assign load_rise = i_max7219_load & ~load_q;
  assign cnt_ok    = cnt == CW'(W);
  assign good      = load_rise && cnt_ok && !any_bad;

  // Split the shift register into per-device words and decide which devices get written
  always_comb begin
    any_bad = 1'b0;
    we = '0;
    for (int k = 0; k < G_NB_DEVICES; k++) begin
      word[k] = sr[16*k +: 12];
      any_bad = any_bad | (word[k].addr != NO_OP && !addr_is_valid(word[k].addr));
    end
    for (int k = 0; k < G_NB_DEVICES; k++) we[k] = good && addr_is_valid(word[k].addr);
  end

  // Select the read-back device; out-of-range devices read as zero
  always_comb begin
    rd_sel = 8'h00;
    for (int k = 0; k < G_NB_DEVICES; k++) if (i_rd_dev == 4'(k)) rd_sel = rd_all[k];
  end

  for (genvar g = 0; g < G_NB_DEVICES; g++) begin : g_dev
    max7219_chain_regfile u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we[g]),
      .addr    (word[g].addr),
      .data    (word[g].data),
      .rd_addr (i_rd_addr),
      .rd_data (rd_all[g])
    );
  end

  // Bus sampling, shifting, bit counting, frame status and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_q            <= 1'b0;
      load_q           <= 1'b0;
      din_q            <= 1'b0;
      sr               <= '0;
      cnt              <= '0;
      o_max7219_dout   <= 1'b0;
      o_frame_received <= 1'b0;
      o_frame_err      <= 1'b0;
      o_dev_written    <= '0;
      o_frame_cnt      <= '0;
      o_err_cnt        <= '0;
    end else begin
      clk_q            <= i_max7219_clk;
      load_q           <= i_max7219_load;
      din_q            <= i_max7219_din;
      if (clk_rise) sr <= {sr[W-2:0], din_q};
      cnt              <= load_rise ? CW'(clk_rise) :
                          (clk_rise && cnt != CW'(W + 1)) ? cnt + CW'(1) : cnt;
      o_max7219_dout   <= sr[W-1];
      o_frame_received <= good;
      o_frame_err      <= load_rise && !good;
      o_dev_written    <= we;
      if (good && o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (load_rise && !good && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

  // Registered read-back; a read colliding with a write sees the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= 8'h00;
    end else begin
      o_rd_valid <= i_rd_req;
      o_rd_data  <= (i_rd_req && addr_is_valid(i_rd_addr)) ? rd_sel : 8'h00;
    end
  end

`ifdef MAX7219_CHAIN_CHECKER_REPORT_EN
  // Report every LOAD rise with its status and decoded words
  always @(posedge clk) begin
    if (rst_n && load_rise) begin
      if (!cnt_ok) $error("matrix %0d: bad bit count %0d", G_MATRIX_ID, cnt);
      else $display("matrix %0d: frame %s", G_MATRIX_ID, any_bad ? "rejected" : "ok");
      for (int k = 0; k < G_NB_DEVICES; k++) begin
        if (cnt_ok && word[k].addr != NO_OP && !addr_is_valid(word[k].addr))
          $error("matrix %0d dev %0d: invalid addr %h", G_MATRIX_ID, k, word[k].addr);
        else
          $display("matrix %0d dev %0d: addr %h data %h", G_MATRIX_ID, k, word[k].addr, word[k].data);
      end
    end
  end
`else
  localparam int unused_id = G_MATRIX_ID;
`endif
endmodule

// File: tb/tb_max7219_chain_checker.sv
// tb_max7219_chain_checker: randomized self-checking bench against a behavioural chain model
module tb_max7219_chain_checker;
  localparam int N = 2;

  logic clk = 0, rst_n = 0, bclk = 0, din = 0, load = 0, rd_req = 0;
  logic [3:0] rd_dev = 0, rd_addr = 0;
  logic dout, rd_valid, frame_received, frame_err;
  logic [7:0] rd_data;
  logic [N-1:0] dev_written;
  logic [15:0] frame_cnt, err_cnt;

  int n_checks = 0, n_errors = 0;
  logic [7:0] m_regs [N][16];
  logic [63:0] m_sr;
  int m_bits, m_fc, m_ec;

  always #5 clk = ~clk;

  max7219_chain_checker #(.G_NB_DEVICES(N), .G_MATRIX_ID(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_max7219_clk    (bclk),
    .i_max7219_din    (din),
    .i_max7219_load   (load),
    .o_max7219_dout   (dout),
    .i_rd_req         (rd_req),
    .i_rd_dev         (rd_dev),
    .i_rd_addr        (rd_addr),
    .o_rd_valid       (rd_valid),
    .o_rd_data        (rd_data),
    .o_frame_received (frame_received),
    .o_frame_err      (frame_err),
    .o_dev_written    (dev_written),
    .o_frame_cnt      (frame_cnt),
    .o_err_cnt        (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit valid_addr(input int a);
    return (a >= 1 && a <= 12) || a == 15;
  endfunction

  task automatic model_reset;
    for (int d = 0; d < N; d++) for (int a = 0; a < 16; a++) m_regs[d][a] = 8'h00;
    m_sr = '0;
    m_bits = 0;
    m_fc = 0;
    m_ec = 0;
  endtask

  task automatic send_bit(input bit b);
    din = b;
    wait_clk(2);
    bclk = 1;
    m_sr = {m_sr[62:0], b};
    m_bits++;
    wait_clk(3);
    bclk = 0;
    wait_clk(2);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic rd_check(input int dev, input int addr);
    logic [7:0] exp;
    exp = (dev < N && valid_addr(addr)) ? m_regs[dev][addr] : 8'h00;
    rd_req = 1;
    rd_dev = 4'(dev);
    rd_addr = 4'(addr);
    wait_clk(1);
    rd_req = 0;
    chk($sformatf("rd valid d%0d a%0h", dev, addr), rd_valid, 1);
    chk($sformatf("rd data d%0d a%0h", dev, addr), rd_data, exp);
    wait_clk(1);
    chk("rd valid pulse end", rd_valid, 0);
  endtask

  task automatic do_load(input string tag);
    bit ok, bad;
    logic [N-1:0] wr;
    logic [15:0] w;
    logic [3:0] rdv, rda;
    logic [7:0] rexp;
    ok = (m_bits == 16 * N);
    bad = 0;
    wr = '0;
    for (int d = 0; d < N; d++) begin
      w = m_sr[16*d +: 16];
      if (w[11:8] == 4'hD || w[11:8] == 4'hE) bad = 1;
    end
    if (ok && !bad) for (int d = 0; d < N; d++) begin
      w = m_sr[16*d +: 16];
      if (valid_addr(int'(w[11:8]))) wr[d] = 1;
    end
    rdv = 4'($urandom_range(0, 3));
    rda = 4'($urandom_range(0, 15));
    rexp = (int'(rdv) < N && valid_addr(int'(rda))) ? m_regs[rdv][rda] : 8'h00;
    load = 1;
    rd_req = 1;
    rd_dev = rdv;
    rd_addr = rda;
    wait_clk(1);
    rd_req = 0;
    chk({tag, " received"}, frame_received, 32'(ok && !bad));
    chk({tag, " err"}, frame_err, 32'(!(ok && !bad)));
    chk({tag, " written"}, dev_written, wr);
    chk({tag, " rd old"}, rd_data, rexp);
    if (ok && !bad) begin
      for (int d = 0; d < N; d++) begin
        w = m_sr[16*d +: 16];
        if (wr[d]) m_regs[d][w[11:8]] = w[7:0];
      end
      m_fc++;
    end else m_ec++;
    m_bits = 0;
    wait_clk(1);
    load = 0;
    chk({tag, " received end"}, frame_received, 0);
    chk({tag, " err end"}, frame_err, 0);
    chk({tag, " written end"}, dev_written, 0);
    chk({tag, " frame_cnt"}, frame_cnt, m_fc);
    chk({tag, " err_cnt"}, err_cnt, m_ec);
  endtask

  initial begin
    logic [31:0] pat;
    logic [63:0] v;
    int n;
    model_reset();
    wait_clk(3);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset dout", dout, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset written", dev_written, 0);
    rst_n = 1;
    wait_clk(2);
    rd_check(0, 10);
    rd_check(1, 10);
    send_bits(64'h0A05_0C01, 32);
    do_load("t2");
    rd_check(1, 10);
    rd_check(0, 12);
    send_bits(64'h0000_0155, 32);
    do_load("t3");
    rd_check(0, 1);
    rd_check(1, 10);
    send_bits(64'h12_3456, 24);
    do_load("t4 short");
    send_bits(64'h0103_0207, 32);
    do_load("t4 good");
    send_bits(64'h0177_0D12, 32);
    do_load("t5 invalid");
    rd_check(1, 1);
    rd_check(0, 2);
    pat = 32'hABCD_1234;
    send_bits(64'(pat), 32);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("t6 dout bit %0d", 31 - j), dout, 32'(pat[31-j]));
      send_bit(0);
    end
    do_load("t6 overrun");
    send_bits(64'h3FF, 10);
    rst_n = 0;
    wait_clk(2);
    model_reset();
    rst_n = 1;
    wait_clk(1);
    chk("midreset frame_cnt", frame_cnt, 0);
    chk("midreset err_cnt", err_cnt, 0);
    rd_check(0, 2);
    send_bits(64'h0F01_0B07, 32);
    do_load("after reset");
    repeat (40) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 40)) : 32;
      v = {$urandom, $urandom};
      send_bits(v, n);
      do_load("rand");
    end
    for (int d = 0; d < 3; d++) for (int a = 0; a < 16; a++) rd_check(d, a);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
